// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
//   Shares a single RAM write port between the CPU core writeback path and a
//   loader/debug path. All outputs are registered, so the requester sampled at
//   a rising Clock edge drives the RAM port until the following edge.
//
//   Optional feature macro: ARB_STARVE_GUARD_EN
//     defined   - the loader's wait cycles are counted; after STARVE_LIMIT
//                 waits the core is stalled for one cycle so the loader wins.
//     undefined - the core has strict priority and oCoreStall is tied to 0.
//
// Parameters
//   DATA_WIDTH    RAM data word width
//   ADDR_WIDTH    RAM address width
//   STARVE_LIMIT  loader wait cycles before the core is stalled (1..255)
//
// Ports
//   Clock            in   rising-edge clock
//   Reset            in   asynchronous active-high reset
//   iCoreWriteEnable in   core writeback request
//   iCoreAddress     in   core write address
//   iCoreData        in   core write data
//   iLoadReq         in   loader write request, held until granted
//   iLoadAddress     in   loader address, stable while iLoadReq=1
//   iLoadData        in   loader data, stable while iLoadReq=1
//   oLoadGrant       out  one-cycle pulse: loader write issued
//   oCoreStall       out  core must freeze and re-present its write
//   oWriteEnable     out  RAM write enable
//   oWriteAddress    out  RAM write address
//   oWriteData       out  RAM write data
module ram_write_arbiter #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 8,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iCoreWriteEnable,
   input  logic [ADDR_WIDTH-1:0] iCoreAddress,
   input  logic [DATA_WIDTH-1:0] iCoreData,
   input  logic                  iLoadReq,
   input  logic [ADDR_WIDTH-1:0] iLoadAddress,
   input  logic [DATA_WIDTH-1:0] iLoadData,
   output logic                  oLoadGrant,
   output logic                  oCoreStall,
   output logic                  oWriteEnable,
   output logic [ADDR_WIDTH-1:0] oWriteAddress,
   output logic [DATA_WIDTH-1:0] oWriteData
);

   logic                  we_q, we_d;
   logic                  grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  core_win;
   logic                  load_win;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [0:0] ARB_NORMAL = 1'b0;
   localparam logic [0:0] ARB_STALL  = 1'b1;
   localparam logic [7:0] LIMIT      = 8'(STARVE_LIMIT);

   logic [0:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   // While stalled the core request is ignored outright; the loader wins if
   // it is still requesting, otherwise the stall cycle issues no write.
   always_comb begin
      if (state_q == ARB_STALL) begin
         core_win = 1'b0;
         load_win = iLoadReq;
      end else begin
         core_win = iCoreWriteEnable;
         load_win = !iCoreWriteEnable && iLoadReq && !grant_q;
      end
   end

   always_comb begin
      if (!iLoadReq || load_win) begin
         cnt_d = '0;
      end else if (cnt_q < LIMIT) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_comb begin
      state_d = ARB_NORMAL;
      if (state_q == ARB_NORMAL && cnt_d == LIMIT) begin
         state_d = ARB_STALL;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ARB_NORMAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign oCoreStall = (state_q == ARB_STALL);
`else
   logic [7:0] unused_starve_limit;
   assign unused_starve_limit = 8'(STARVE_LIMIT);

   // Strict core priority; the loader only takes idle cycles and never on
   // two consecutive edges.
   always_comb begin
      core_win = iCoreWriteEnable;
      load_win = !iCoreWriteEnable && iLoadReq && !grant_q;
   end

   assign oCoreStall = 1'b0;
`endif

   always_comb begin
      we_d    = core_win || load_win;
      grant_d = load_win;
      addr_d  = addr_q;
      data_d  = data_q;
      if (load_win) begin
         addr_d = iLoadAddress;
         data_d = iLoadData;
      end else if (core_win) begin
         addr_d = iCoreAddress;
         data_d = iCoreData;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         we_q    <= 1'b0;
         grant_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         we_q    <= we_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign oWriteEnable  = we_q;
   assign oLoadGrant    = grant_q;
   assign oWriteAddress = addr_q;
   assign oWriteData    = data_q;

endmodule
